xbus_pkt_sched: RTL

- Sequencer that drives the X-bus feeding the chain of `P xbus filters.
- On a start pulse it walks the input feature map (row, then column, then channel group) and issues linear reads to the X buffer.
- It attaches a tag to each returned `Q*`S-byte word and launches it onto the bus as one packet.
- It throttles issue whenever any filter reports cache_full, then signals done once the last packet has left.

---
 rtl/xbus_pkt_sched_pkg.sv | 44 ++++
 rtl/xbus_pkt_sched_tag_delay.sv | 38 +++
 rtl/xbus_pkt_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/xbus_pkt_sched_pkg.sv
// Shared definitions for the X-bus packet sequencer and the filters it feeds.
//   - Bus geometry: XBUS_P filters, XBUS_Q*XBUS_S bytes per bus word.
//   - Tag layout, LSB first: ch[15:0], col[15:0], row[15:0], last, vld.
//     The filters decode tags with these same constants.
//   - Sequencer state encoding (also exported on the debug port).
package xbus_pkt_sched_pkg;

  localparam int XBUS_P      = 4;
  localparam int XBUS_Q      = 2;
  localparam int XBUS_S      = 2;
  localparam int XBUS_DATA_W = XBUS_Q * XBUS_S * 8;

  localparam int XBUS_TAG_CH    = 0;
  localparam int XBUS_TAG_COL   = 16;
  localparam int XBUS_TAG_ROW   = 32;
  localparam int XBUS_TAG_LAST  = 48;
  localparam int XBUS_TAG_VLD   = 49;
  localparam int XBUS_TAG_WIDTH = 50;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Build a valid tag; bubbles are represented by an all-zero tag.
  function automatic logic [XBUS_TAG_WIDTH-1:0] make_tag(
    input logic        last,
    input logic [15:0] row,
    input logic [15:0] col,
    input logic [15:0] ch
  );
    logic [XBUS_TAG_WIDTH-1:0] t;
    t                         = '0;
    t[XBUS_TAG_CH  +: 16]     = ch;
    t[XBUS_TAG_COL +: 16]     = col;
    t[XBUS_TAG_ROW +: 16]     = row;
    t[XBUS_TAG_LAST]          = last;
    t[XBUS_TAG_VLD]           = 1'b1;
    return t;
  endfunction

endpackage

// File: rtl/xbus_pkt_sched_tag_delay.sv
// xbus_tag_delay: DEPTH-stage shift register carrying a tag (with its valid
// bit) alongside an X-buffer read, so the tag emerges in the same cycle as
// the read data.
//   clk, rst   : clock, asynchronous active-high reset (clears all stages)
//   tag_in     : tag of the read issued this cycle, all-zero for no read
//   tag_out    : tag aligned with the read data (DEPTH cycles later)
//   any_valid  : some stage still holds a valid tag (reads in flight)
module xbus_tag_delay
  import xbus_pkt_sched_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [XBUS_TAG_WIDTH-1:0] tag_in,
  output logic [XBUS_TAG_WIDTH-1:0] tag_out,
  output logic                      any_valid
);

  logic [XBUS_TAG_WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign tag_out = sr[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) any_valid = any_valid | sr[i][XBUS_TAG_VLD];
  end

endmodule

// File: rtl/xbus_pkt_sched.sv
// xbus_pkt_sched: walks the input feature map (channel group fastest, then
// column, then row), issues linear X-buffer reads and launches each returned
// word onto the X-bus as one tagged packet. Issue pauses while any filter
// reports cache_full; done pulses once the last packet has left.
//
// Protocol: start is a one-cycle pulse sampled only in IDLE; there is no
// back-pressure on the bus itself -- cache_full only throttles new reads, and
// reads already in flight are always delivered.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : job start pulse
//   INC2_minus_1      : channel groups per pixel minus 1
//   INH2, INW2        : rows / columns to stream (0 => empty job)
//   xbuf_base         : first X-buffer word address
//   busy, done        : job in progress / one-cycle completion pulse
//   xbuf_rd_en/addr   : X-buffer read strobe and address
//   xbuf_rd_data      : read data, valid RD_LAT cycles after xbuf_rd_en
//   cache_full        : per-filter almost-full flags
//   pkt_tag, pkt_data : registered bus outputs (vld=0 => bubble, data=0)
//   state_dbg         : current sequencer state
module xbus_pkt_sched
  import xbus_pkt_sched_pkg::*;
#(
  parameter int RD_LAT = 2,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [15:0]               INC2_minus_1,
  input  logic [15:0]               INH2,
  input  logic [15:0]               INW2,
  input  logic [ADDR_W-1:0]         xbuf_base,
  output logic                      busy,
  output logic                      done,
  output logic                      xbuf_rd_en,
  output logic [ADDR_W-1:0]         xbuf_rd_addr,
  input  logic [XBUS_DATA_W-1:0]    xbuf_rd_data,
  input  logic [XBUS_P-1:0]         cache_full,
  output logic [XBUS_TAG_WIDTH-1:0] pkt_tag,
  output logic [XBUS_DATA_W-1:0]    pkt_data,
  output logic [1:0]                state_dbg
);

  state_t              state;
  logic [15:0]         c_r, h_r, w_r;
  logic [ADDR_W-1:0]   base_r;
  logic [15:0]         ch, col, row;
  logic [ADDR_W-1:0]   lin;
  logic                stall_r;

  logic                issue;
  logic                is_last;
  logic                ch_wrap;
  logic                col_wrap;
  logic [XBUS_TAG_WIDTH-1:0] issue_tag;
  logic [XBUS_TAG_WIDTH-1:0] dly_tag;
  logic                      dly_any_valid;

  // cache_full is registered once; the filters' full margin covers the
  // extra cycle plus the reads already in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_r <= 1'b0;
    else     stall_r <= |cache_full;
  end

  assign issue    = (state == ST_RUN) && !stall_r;
  assign ch_wrap  = (ch  == c_r);
  assign col_wrap = (col == 16'(w_r - 16'd1));
  assign is_last  = ch_wrap && col_wrap && (row == 16'(h_r - 16'd1));

  // The read strobe is combinational on issue so a stall blocks the read in
  // the same cycle stall_r is high.
  assign xbuf_rd_en   = issue;
  assign xbuf_rd_addr = base_r + lin;
  assign issue_tag    = issue ? make_tag(is_last, row, col, ch) : '0;
  assign state_dbg    = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      c_r    <= '0;
      h_r    <= '0;
      w_r    <= '0;
      base_r <= '0;
      ch     <= '0;
      col    <= '0;
      row    <= '0;
      lin    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            c_r    <= INC2_minus_1;
            h_r    <= INH2;
            w_r    <= INW2;
            base_r <= xbuf_base;
            ch     <= '0;
            col    <= '0;
            row    <= '0;
            lin    <= '0;
            busy   <= 1'b1;
            // An empty map issues nothing but still completes through DRAIN.
            state  <= (INH2 == 16'd0 || INW2 == 16'd0) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            lin <= lin + ADDR_W'(1);
            if (is_last) begin
              state <= ST_DRAIN;
            end else if (ch_wrap) begin
              ch <= '0;
              if (col_wrap) begin
                col <= '0;
                row <= row + 16'd1;
              end else begin
                col <= col + 16'd1;
              end
            end else begin
              ch <= ch + 16'd1;
            end
          end
        end
        ST_DRAIN: begin
          // Once the delay line is empty the last packet is in the output
          // register, so done lands in the cycle right after it.
          if (!dly_any_valid) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  xbus_tag_delay #(
    .DEPTH (RD_LAT)
  ) u_tag_delay (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (issue_tag),
    .tag_out   (dly_tag),
    .any_valid (dly_any_valid)
  );

  // Bus output register: data is forced to zero on bubbles so stale or
  // undriven X-buffer output never reaches the filters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_tag  <= '0;
      pkt_data <= '0;
    end else begin
      pkt_tag  <= dly_tag;
      pkt_data <= dly_tag[XBUS_TAG_VLD] ? xbuf_rd_data : '0;
    end
  end

endmodule
